// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory request/response, execute redirect, decode handoff.
// The fetch unit takes the master side; memory, execute and decode together form the slave side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, DEPTH-entry {pc, instr} prefetch queue,
// redirect flush with in-flight response discard.
//
// state     | meaning
// ----------+------------------------------------------------
// S_IDLE    | no request outstanding, may issue a new fetch
// S_WAIT    | request outstanding, response will be queued
// S_DISCARD | request outstanding, response will be dropped
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned    PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]    PC_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [31:0]      fetch_pc_q;
    logic [31:0]      pend_pc_q;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   fill;

    logic             outstanding;
    logic             req;
    logic             fire;
    logic             push;
    logic             pop;
    logic             head_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response arriving together with a redirect still retires the request, so rvalid wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = S_IDLE;
                end else if (bus.redirect_valid) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (bus.imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        outstanding = (state_q != S_IDLE);
        fill        = count_q + (PTR_W + 1)'(outstanding);
        req         = !rst && !bus.redirect_valid && !outstanding && (fill < DEPTH_CNT);
        fire        = req && bus.imem_gnt;
        push        = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
        head_valid  = (count_q != '0);
        pop         = head_valid && bus.instr_ready && !bus.redirect_valid;
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? instr_mem[rd_ptr_q] : '0;
    assign bus.instr_pc    = head_valid ? pc_mem[rd_ptr_q]    : '0;

    // fetch_pc_q is kept word-aligned at all times so it can drive imem_addr directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & PC_MASK;
            pend_pc_q  <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc_q <= bus.redirect_pc & PC_MASK;
        end else if (fire) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            pend_pc_q  <= fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only observable while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= pend_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenario tasks plus a randomized run against a
// queue-based reference model of the fetch unit.
module tb_instr_fetch_unit;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", bus.imem_req); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", bus.instr); end
        n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr_pc: got %h want 0", bus.instr_pc); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rel_req: got %0b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL rel_addr: got %h want %h", bus.imem_addr, RESET_PC); end
    endtask

    task automatic test_in_order();
        logic [31:0] d [3];
        apply_reset();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) d[i] = $urandom();
        for (int i = 0; i < 3; i++) begin
            bus.imem_gnt    = 1'b1;
            bus.imem_rvalid = 1'b0;
            #1;
            n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL ord_req[%0d]: got %0b want 1", i, bus.imem_req); end
            n_cmp++; if (bus.imem_addr !== 32'(4 * i)) begin n_err++; $display("FAIL ord_addr[%0d]: got %h want %h", i, bus.imem_addr, 32'(4 * i)); end
            if (i > 0) begin
                n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL ord_valid[%0d]: got %0b want 1", i, bus.instr_valid); end
                n_cmp++; if (bus.instr_pc !== 32'(4 * (i - 1))) begin n_err++; $display("FAIL ord_pc[%0d]: got %h want %h", i, bus.instr_pc, 32'(4 * (i - 1))); end
                n_cmp++; if (bus.instr !== d[i-1]) begin n_err++; $display("FAIL ord_instr[%0d]: got %h want %h", i, bus.instr, d[i-1]); end
            end
            cyc();
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = d[i];
            #1;
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL ord_wait_req[%0d]: got %0b want 0", i, bus.imem_req); end
            n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL ord_wait_valid[%0d]: got %0b want 0", i, bus.instr_valid); end
            cyc();
        end
        bus.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL ord_last_valid: got %0b want 1", bus.instr_valid); end
        n_cmp++; if (bus.instr_pc !== 32'h8) begin n_err++; $display("FAIL ord_last_pc: got %h want 8", bus.instr_pc); end
        n_cmp++; if (bus.instr !== d[2]) begin n_err++; $display("FAIL ord_last_instr: got %h want %h", bus.instr, d[2]); end
        cyc();
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.instr_ready = 1'b0;
        bus.imem_gnt    = 1'b1;
        cyc();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = $urandom();
        cyc();
        bus.imem_rvalid = 1'b0;
        bus.imem_gnt    = 1'b1;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'h4) begin n_err++; $display("FAIL bp_addr1: got %h want 4", bus.imem_addr); end
        cyc();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = $urandom();
        cyc();
        bus.imem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL bp_full_req[%0d]: got %0b want 0", k, bus.imem_req); end
            n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL bp_full_head[%0d]: got %h want 0", k, bus.instr_pc); end
            cyc();
        end
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        #1;
        n_cmp++; if (bus.instr_pc !== 32'h4) begin n_err++; $display("FAIL bp_second: got %h want 4", bus.instr_pc); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL bp_resume_req: got %0b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_resume_addr: got %h want 8", bus.imem_addr); end
        cyc();
    endtask

    task automatic test_redirect();
        logic [31:0] d100;
        d100 = $urandom();
        apply_reset();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.imem_gnt    = 1'b1;
            bus.imem_rvalid = 1'b0;
            cyc();
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = $urandom();
            cyc();
        end
        bus.imem_rvalid = 1'b0;
        bus.instr_ready = 1'b0;
        bus.imem_gnt    = 1'b1;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL rd_addr8: got %h want 8", bus.imem_addr); end
        cyc();
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rd_req_during: got %0b want 0", bus.imem_req); end
        n_cmp++; if (bus.instr_pc !== 32'h4) begin n_err++; $display("FAIL rd_head_before: got %h want 4", bus.instr_pc); end
        cyc();
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rd_req_discard: got %0b want 0", bus.imem_req); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rd_flush: got %0b want 0", bus.instr_valid); end
        cyc();
        bus.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rd_dropped: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rd_req_new: got %0b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL rd_addr_new: got %h want 100", bus.imem_addr); end
        bus.imem_gnt = 1'b1;
        cyc();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d100;
        cyc();
        bus.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL rd_new_valid: got %0b want 1", bus.instr_valid); end
        n_cmp++; if (bus.instr_pc !== 32'h100) begin n_err++; $display("FAIL rd_new_pc: got %h want 100", bus.instr_pc); end
        n_cmp++; if (bus.instr !== d100) begin n_err++; $display("FAIL rd_new_instr: got %h want %h", bus.instr, d100); end
        cyc();
    endtask

    task automatic test_redirect_rvalid();
        apply_reset();
        bus.instr_ready = 1'b0;
        bus.imem_gnt    = 1'b1;
        cyc();
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = $urandom();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rr_req_same: got %0b want 0", bus.imem_req); end
        cyc();
        bus.imem_rvalid    = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rr_not_queued: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rr_req_next: got %0b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL rr_addr_next: got %h want 40", bus.imem_addr); end
        cyc();
        #1;
        n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL rr_addr_hold: got %h want 40", bus.imem_addr); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h87;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rr_idle_redirect_req: got %0b want 0", bus.imem_req); end
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rr_idle_next_req: got %0b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h84) begin n_err++; $display("FAIL rr_idle_next_addr: got %h want 84", bus.imem_addr); end
        cyc();
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        d = $urandom();
        apply_reset();
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top: got %h want fffffffc", bus.imem_addr); end
        bus.imem_gnt = 1'b1;
        cyc();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        cyc();
        bus.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req: got %0b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.instr_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc: got %h want fffffffc", bus.instr_pc); end
        n_cmp++; if (bus.instr !== d) begin n_err++; $display("FAIL wrap_instr: got %h want %h", bus.instr, d); end
        cyc();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.instr_ready = 1'b0;
        bus.imem_gnt    = 1'b1;
        cyc();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = $urandom() | 32'h1;
        cyc();
        bus.imem_rvalid = 1'b0;
        bus.imem_gnt    = 1'b1;
        cyc();
        bus.imem_gnt = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid: got %0b want 1", bus.instr_valid); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rm_req: got %0b want 0", bus.imem_req); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rm_instr: got %h want 0", bus.instr); end
        n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL rm_pc: got %h want 0", bus.instr_pc); end
        cyc();
        rst             = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h5A5A_5A5A;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rm_rel_req: got %0b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL rm_rel_addr: got %h want %h", bus.imem_addr, RESET_PC); end
        cyc();
        bus.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rm_stale: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rm_stale_req: got %0b want 1", bus.imem_req); end
        cyc();
    endtask

    // Reference: a queue of {pc, instr}, the next fetch address, and whether a request is in
    // flight and whether its data is still wanted. The memory side grants and answers at random.
    task automatic test_random();
        logic [63:0] q[$];
        logic [31:0] m_pc, m_tag, rpc, rdat;
        logic        m_out, m_drop, m_req, mem_pend, redir, gnt, rv, rdy;
        int          mem_lat;
        apply_reset();
        m_pc     = RESET_PC & 32'hFFFF_FFFC;
        m_tag    = '0;
        m_out    = 1'b0;
        m_drop   = 1'b0;
        mem_pend = 1'b0;
        mem_lat  = 0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            redir = ($urandom_range(0, 15) == 0);
            rpc   = $urandom();
            rdy   = ($urandom_range(0, 3) != 0);
            gnt   = ($urandom_range(0, 2) != 0);
            rdat  = $urandom();
            if (mem_pend) rv = (mem_lat == 0);
            else          rv = ($urandom_range(0, 15) == 0);
            m_req = !m_out && !redir && (q.size() < int'(DEPTH));
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;
            bus.instr_ready    = rdy;
            bus.imem_gnt       = gnt;
            bus.imem_rvalid    = rv;
            bus.imem_rdata     = rdat;
            #1;
            n_cmp++; if (bus.imem_req !== m_req) begin n_err++; $display("FAIL rnd_req @%0d: got %0b want %0b", c, bus.imem_req, m_req); end
            n_cmp++; if (bus.imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr @%0d: got %h want %h", c, bus.imem_addr, m_pc); end
            n_cmp++; if (bus.instr_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid @%0d: got %0b want %0b", c, bus.instr_valid, q.size() > 0); end
            if (q.size() > 0) begin
                n_cmp++; if (bus.instr_pc !== q[0][63:32]) begin n_err++; $display("FAIL rnd_pc @%0d: got %h want %h", c, bus.instr_pc, q[0][63:32]); end
                n_cmp++; if (bus.instr !== q[0][31:0]) begin n_err++; $display("FAIL rnd_instr @%0d: got %h want %h", c, bus.instr, q[0][31:0]); end
            end
            cyc();
            if (mem_pend) begin
                if (rv) mem_pend = 1'b0;
                else    mem_lat--;
            end
            if (redir) begin
                q.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
                if (m_out) begin
                    if (rv) begin
                        m_out  = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end else begin
                if (q.size() > 0 && rdy) void'(q.pop_front());
                if (m_out && rv) begin
                    if (!m_drop) q.push_back({m_tag, rdat});
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end
                if (m_req && gnt) begin
                    m_tag    = m_pc;
                    m_pc     = m_pc + 32'd4;
                    m_out    = 1'b1;
                    mem_pend = 1'b1;
                    mem_lat  = $urandom_range(0, 3);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_in_order();
        test_backpressure();
        test_redirect();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
